// File: rtl/m10k_bank_initializer.sv
// m10k_bank_initializer
//
// Owns NUM_COLS independent inferred M10K columns, each DEPTH x DATA_W.
// The ARM fills the columns over PIO. Columns are filled one after another,
// rows in ascending address order. Any write that breaks that order is
// dropped and the block latches an error. Once every column holds `height`
// rows, the columns pass to the compute datapath, which has its own
// read/write port per column. A reinit pulse restarts the load sequence
// without clearing memory contents.
//
// Handshake: pio_wr_en is a single-cycle strobe and carries exactly one word.
// There is no back-pressure. A strobe counts only when init_en is high.
// we_cn[c] is a single-cycle strobe and is honoured only in READY.
//
// Ports:
//   clk, reset    clock; asynchronous active-low reset
//   init_en       ARM permits loading (low pauses LOAD)
//   reinit        one-cycle restart of the load sequence
//   pio_height    rows per column, latched on IDLE->LOAD
//   pio_col/pio_wr_addr/pio_d/pio_wr_en   PIO write port
//   rd_addr_cn, wr_addr_cn, we_cn, d_cn   packed per-column datapath ports
//   q_cn          packed per-column registered read data (1-cycle latency)
//   done, err     load complete / sequence violation
//   cur_col       column currently being loaded
module m10k_bank_initializer #(
   parameter  int DATA_W   = 18,
   parameter  int ADDR_W   = 9,
   parameter  int NUM_COLS = 4,
   localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         init_en,
   input  logic                         reinit,
   input  logic [ADDR_W:0]              pio_height,
   input  logic [COL_W-1:0]             pio_col,
   input  logic [ADDR_W-1:0]            pio_wr_addr,
   input  logic [DATA_W-1:0]            pio_d,
   input  logic                         pio_wr_en,
   input  logic [NUM_COLS*ADDR_W-1:0]   rd_addr_cn,
   input  logic [NUM_COLS*ADDR_W-1:0]   wr_addr_cn,
   input  logic [NUM_COLS-1:0]          we_cn,
   input  logic [NUM_COLS*DATA_W-1:0]   d_cn,
   output logic [NUM_COLS*DATA_W-1:0]   q_cn,
   output logic                         done,
   output logic                         err,
   output logic [COL_W-1:0]             cur_col
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_H   = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_ERROR} state_t;

   state_t              state_q,    state_d;
   logic [ADDR_W:0]     height_q,   height_d;
   logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
   logic [COL_W-1:0]    cur_col_q,  cur_col_d;
   logic                done_q,     done_d;
   logic                err_q,      err_d;
   logic                pio_accept;
   logic                pio_hit;
   logic                row_last;
   logic                col_last;

   assign pio_hit  = (pio_col == cur_col_q) && (pio_wr_addr == exp_addr_q);
   assign row_last = ({1'b0, exp_addr_q} == (height_q - ONE_H));
   assign col_last = (cur_col_q == COL_W'(NUM_COLS - 1));

   always_comb begin
      state_d    = state_q;
      height_d   = height_q;
      exp_addr_d = exp_addr_q;
      cur_col_d  = cur_col_q;
      done_d     = done_q;
      err_d      = err_q;
      pio_accept = 1'b0;

      if (reinit) begin
         // Restart wins over everything, including a strobe on this cycle.
         state_d    = S_IDLE;
         exp_addr_d = '0;
         cur_col_d  = '0;
         done_d     = 1'b0;
         err_d      = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (init_en) begin
                  height_d = pio_height;
                  if ((pio_height == '0) || (pio_height > DEPTH_V)) begin
                     state_d = S_ERROR;
                     err_d   = 1'b1;
                  end else begin
                     state_d    = S_LOAD;
                     exp_addr_d = '0;
                     cur_col_d  = '0;
                  end
               end
            end
            S_LOAD: begin
               if (init_en && pio_wr_en) begin
                  if (pio_hit) begin
                     pio_accept = 1'b1;
                     if (row_last) begin
                        exp_addr_d = '0;
                        if (col_last) begin
                           // done rises on the edge of the final word.
                           state_d = S_READY;
                           done_d  = 1'b1;
                        end else begin
                           cur_col_d = cur_col_q + COL_W'(1);
                        end
                     end else begin
                        exp_addr_d = exp_addr_q + ADDR_W'(1);
                     end
                  end else begin
                     state_d = S_ERROR;
                     err_d   = 1'b1;
                  end
               end
            end
            default: ;  // READY and ERROR hold until reinit or reset
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         height_q   <= '0;
         exp_addr_q <= '0;
         cur_col_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         height_q   <= height_d;
         exp_addr_q <= exp_addr_d;
         cur_col_q  <= cur_col_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign done    = done_q;
   assign err     = err_q;
   assign cur_col = cur_col_q;

   // One simple dual-port RAM per column. Each column's write port is owned
   // by PIO during LOAD and by the datapath in READY.
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rd_q;
      logic              mem_we;
      logic [ADDR_W-1:0] mem_wa;
      logic [DATA_W-1:0] mem_wd;

      always_comb begin
         mem_we = 1'b0;
         mem_wa = pio_wr_addr;
         mem_wd = pio_d;
         if (state_q == S_READY) begin
            mem_we = we_cn[c] && !reinit;
            mem_wa = wr_addr_cn[c*ADDR_W +: ADDR_W];
            mem_wd = d_cn[c*DATA_W +: DATA_W];
         end else if (pio_accept && (cur_col_q == COL_W'(c))) begin
            mem_we = 1'b1;
         end
      end

      // Non-blocking read and write give old data on read-during-write.
      always_ff @(posedge clk) begin
         if (mem_we) begin
            mem[mem_wa] <= mem_wd;
         end
         rd_q <= mem[rd_addr_cn[c*ADDR_W +: ADDR_W]];
      end

      assign q_cn[c*DATA_W +: DATA_W] = rd_q;
   end

endmodule

// File: doc/m10k_bank_initializer.md
Name: m10k_bank_initializer

Overview:
- Parametrised successor of the single-column M10K loader. Owns NUM_COLS independent inferred M10K columns, each DEPTH x DATA_W.
- The ARM fills the columns over PIO, column-major and in address order. The block checks that sequence and flags any violation.
- Once loaded, the block hands every column to the compute datapath through per-column read/write ports.
- Supports re-initialisation without a global reset.

Parameters:
DATA_W, 18, word width of each column
ADDR_W, 9, address width; DEPTH = 2**ADDR_W (512)
NUM_COLS, 4, number of independent memory columns; COL_W = max(1, clog2(NUM_COLS)) (localparam)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
init_en  in  1  ARM permits loading; low pauses LOAD
reinit  in  1  one-cycle pulse: restart load sequence, memory contents retained
pio_height  in  ADDR_W+1  rows per column to load; latched on IDLE->LOAD
pio_col  in  COL_W  target column of PIO write
pio_wr_addr  in  ADDR_W  target row of PIO write
pio_d  in  DATA_W  PIO write data
pio_wr_en  in  1  PIO write strobe, one cycle per word
rd_addr_cn  in  NUM_COLS*ADDR_W  per-column read address, column c at [c*ADDR_W +: ADDR_W]
wr_addr_cn  in  NUM_COLS*ADDR_W  per-column write address
we_cn  in  NUM_COLS  per-column write enable (honoured only in READY)
d_cn  in  NUM_COLS*DATA_W  per-column write data
q_cn  out  NUM_COLS*DATA_W  per-column registered read data
done  out  1  all columns loaded; memories owned by datapath
err  out  1  load sequence violation
cur_col  out  COL_W  column currently being loaded (progress)

Behaviour:
- Reset (reset=0, async): state IDLE; done=0, err=0, cur_col=0, internal exp_addr=0. q_cn is undefined until the first read after reset. Memory contents are not cleared.
- Reads: q_cn[c] = mem[c][rd_addr_cn[c]] registered, 1-cycle latency, valid in every state.
- Read-during-write to the same address returns old data.
- IDLE:
  - init_en=1 -> latch height = pio_height.
  - If height==0 or height>DEPTH -> ERROR; else -> LOAD with cur_col=0, exp_addr=0.
- LOAD:
  - With init_en=0: pio_wr_en is ignored; no state change, no error.
  - Accepted write: init_en && pio_wr_en && pio_col==cur_col && pio_wr_addr==exp_addr. Writes pio_d into column cur_col.
  - After an accepted write with exp_addr==height-1: exp_addr<=0, cur_col++.
  - If that was the last column (cur_col==NUM_COLS-1): -> READY, and done=1 on the same clock edge as the final write. There is no extra stall cycle.
  - Otherwise exp_addr++.
  - Any pio_wr_en with wrong column or address: write suppressed; -> ERROR at that edge.
- READY:
  - done=1, err=0.
  - Memory write port c is driven by wr_addr_cn/d_cn/we_cn[c]. All pio_wr_en is ignored.
  - State held until reinit or reset.
- ERROR:
  - err=1, done=0; all memory writes blocked, both PIO and datapath.
  - State held until reinit or reset.
- Outside READY, we_cn is ignored.
- reinit=1 in any state -> IDLE at next edge:
  - done=0, err=0, cur_col=0, exp_addr=0.
  - A simultaneous pio_wr_en or we_cn on that cycle is not written.
- reset wins over reinit. Assertion mid-LOAD aborts immediately; partially written words remain.
- height==DEPTH is legal: exp_addr reaches DEPTH-1, then advances to the next column.
- NUM_COLS==1: cur_col is a constant 0 and pio_col must be 0.

Test Plan:
- Legal load: NUM_COLS=4, height=31; write cols 0..3, rows 0..30, data = col*100+row. Required: done rises on the edge of the 124th write; then rd_addr_cn col2=29 gives q_cn col2=229 one cycle later.
- Datapath write: in READY, we_cn[3]=1, wr_addr=30, d=17, while PIO strobes addr 5 col 0 data 999. Required: col3 row30 reads 17; col0 row5 unchanged (5).
- Order violation: height=8; write col0 rows 0,1,3. Required: err=1 on the row-3 edge, row 3 not written, done=0; later pio writes ignored.
- Pause and bounds: init_en low for 10 cycles mid-column with strobes present -> no error, no writes. height=0 -> ERROR. height=512 -> full-depth load completes.
- Reinit: in READY, pulse reinit. Required: done=0 next cycle; old data still readable; a full reload with new data reaches done=1 with the new values.
- Async reset: assert reset low between clock edges mid-LOAD. Required: done, err and cur_col clear immediately without waiting for clk; a fresh load after release succeeds.
